// File: rtl/tr_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// tr_step_ctrl_if
//
// Purpose: bundles the ADC-side sample strobe, the tracking configuration and
// the stepper-driver outputs of tr_step_ctrl into one interface.
//
// Handshake: data_valid is a one-cycle strobe with no backpressure (there is
// no ready). The controller takes a sample only when it is idle and
// tr_mode_enable is high. A strobe at any other time is dropped, not queued.
// The producer never waits on the controller.
//
// Signals:
//   data_valid, tr_mode_enable      strobe and tracking permit
//   x, x0, dx1, dx2                 sample, setpoint, deadband, coarse band (DW)
//   step_hi, step_lo                pulse high/low time in clk cycles (PW)
//   n_fine, n_coarse                steps per move for each band (CW)
//   drv_enable_SM, drv_step, drv_dir  stepper driver pins
//   busy, led, step_count           status
//   dbg_state                       FSM state, for observation only
//
// Modports: master = sample source / configuration owner, slave = controller.
// ---------------------------------------------------------------------------
interface tr_step_ctrl_if #(
   parameter int DW = 12,
   parameter int CW = 10,
   parameter int PW = 8
);
   logic          data_valid;
   logic          tr_mode_enable;
   logic [DW-1:0] x;
   logic [DW-1:0] x0;
   logic [DW-1:0] dx1;
   logic [DW-1:0] dx2;
   logic [PW-1:0] step_hi;
   logic [PW-1:0] step_lo;
   logic [CW-1:0] n_fine;
   logic [CW-1:0] n_coarse;

   logic          drv_enable_SM;
   logic          drv_step;
   logic          drv_dir;
   logic          busy;
   logic          led;
   logic [CW-1:0] step_count;
   logic [2:0]    dbg_state;

   modport master (
      output data_valid, tr_mode_enable, x, x0, dx1, dx2,
             step_hi, step_lo, n_fine, n_coarse,
      input  drv_enable_SM, drv_step, drv_dir, busy, led, step_count, dbg_state
   );

   modport slave (
      input  data_valid, tr_mode_enable, x, x0, dx1, dx2,
             step_hi, step_lo, n_fine, n_coarse,
      output drv_enable_SM, drv_step, drv_dir, busy, led, step_count, dbg_state
   );
endinterface

// File: rtl/tr_step_ctrl.sv
// ---------------------------------------------------------------------------
// tr_step_ctrl
//
// Purpose: compares each accepted ADC sample against a setpoint using a
// deadband and a coarse band, and then drives a bounded burst of stepper
// pulses toward the setpoint. Pulse timing, direction and step count are
// latched when the sample is accepted, so a move cannot be disturbed by
// configuration changes while it runs.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   tr_step_ctrl_if.slave: sample/config inputs, driver/status outputs
//
// Move timeline (one move of n steps):
//   SETUP (1) -> n x [STEP_HI (hi cycles), STEP_LO (lo cycles)] -> DONE (1)
// ---------------------------------------------------------------------------
module tr_step_ctrl #(
   parameter int DW = 12,
   parameter int CW = 10,
   parameter int PW = 8
) (
   input logic           clk,
   input logic           rst,
   tr_step_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STEP_HI = 3'd2,
      S_STEP_LO = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] n_q, n_d;        // step target of the running move
   logic [PW-1:0] hi_q, hi_d;      // latched high time, already forced >= 1
   logic [PW-1:0] lo_q, lo_d;      // latched low time, already forced >= 1
   logic [PW-1:0] tmr_q, tmr_d;    // cycles left in the current phase, minus 1
   logic [CW-1:0] cnt_q, cnt_d;    // steps issued in the current/last move
   logic          dir_q, dir_d;
   logic          led_q, led_d;

   // Error magnitude in DW+1 bits so that |x - x0| never wraps.
   logic [DW:0]   x_ext, x0_ext, abs_err;
   logic          err_pos;
   logic          in_dead;
   logic          in_fine;
   logic [CW-1:0] n_sel;
   logic [PW-1:0] hi_eff, lo_eff;
   logic          accept;

   always_comb begin
      x_ext   = {1'b0, bus.x};
      x0_ext  = {1'b0, bus.x0};
      abs_err = (x_ext >= x0_ext) ? (x_ext - x0_ext) : (x0_ext - x_ext);
      err_pos = (bus.x > bus.x0);
      in_dead = (abs_err <= {1'b0, bus.dx1});
      in_fine = (abs_err <= {1'b0, bus.dx2});
      n_sel   = in_fine ? bus.n_fine : bus.n_coarse;
      // A programmed time of 0 would give an empty phase; run it as 1 cycle.
      hi_eff  = (bus.step_hi == '0) ? PW'(1) : bus.step_hi;
      lo_eff  = (bus.step_lo == '0) ? PW'(1) : bus.step_lo;
      accept  = bus.data_valid && bus.tr_mode_enable;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      led_d   = led_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (in_dead) begin
                  led_d = 1'b1;
               end else begin
                  led_d = 1'b0;
                  // A zero step count leaves step_count showing the last move.
                  if (n_sel != '0) begin
                     n_d     = n_sel;
                     hi_d    = hi_eff;
                     lo_d    = lo_eff;
                     cnt_d   = '0;
                     dir_d   = err_pos;
                     state_d = S_SETUP;
                  end
               end
            end
         end

         S_SETUP: begin
            state_d = S_STEP_HI;
            cnt_d   = cnt_q + CW'(1);
            tmr_d   = hi_q - PW'(1);
         end

         S_STEP_HI: begin
            if (tmr_q == '0) begin
               state_d = S_STEP_LO;
               tmr_d   = lo_q - PW'(1);
            end else begin
               tmr_d = tmr_q - PW'(1);
            end
         end

         S_STEP_LO: begin
            if (tmr_q == '0) begin
               // Abort is only honoured here, so a pulse is never cut short.
               if ((cnt_q == n_q) || !bus.tr_mode_enable) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_STEP_HI;
                  cnt_d   = cnt_q + CW'(1);
                  tmr_d   = hi_q - PW'(1);
               end
            end else begin
               tmr_d = tmr_q - PW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         led_q   <= led_d;
      end
   end

   // Outputs are decoded from registered state only.
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.drv_enable_SM = (state_q != S_IDLE);
   assign bus.drv_step      = (state_q == S_STEP_HI);
   assign bus.drv_dir       = dir_q;
   assign bus.led           = led_q;
   assign bus.step_count    = cnt_q;
   assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_tr_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tr_step_ctrl
//
// Directed bench for tr_step_ctrl. On each accepted sample a behavioural
// model turns the move rules into the complete expected per-cycle output
// trace (busy, enable, step, dir, led, step_count) and queues it. A compare
// process checks the DUT against the head of that queue every cycle, or
// against the model's idle values once the queue is empty. Literal checks
// pin latency, busy length and final counts of the listed scenarios.
// ---------------------------------------------------------------------------
module tb_tr_step_ctrl;

   localparam int DW = 12;
   localparam int CW = 10;
   localparam int PW = 8;
   localparam int EW = CW + 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tr_step_ctrl_if #(.DW(DW), .CW(CW), .PW(PW)) bus ();

   tr_step_ctrl #(.DW(DW), .CW(CW), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- bench configuration mirror ----------------
   int c_x0, c_dx1, c_dx2, c_hi, c_lo, c_n_fine, c_n_coarse;
   bit c_en;

   // ---------------- model / scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   bit            m_dir, m_led;
   int            m_cnt;
   bit            m_busy_prev;
   bit            chk_en = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;
   int            busy_cyc = 0;
   logic [EW-1:0] e_cur, a_cur;
   int            cyc = 0;

   function automatic logic [EW-1:0] mk(bit b, bit en, bit st, bit d, bit l, int c);
      logic [CW-1:0] cc;
      cc = c[CW-1:0];
      return {b, en, st, d, l, cc};
   endfunction

   // Decide what an accepted sample does, from the move rules, and queue
   // the whole expected trace of the resulting move. n_force >= 0 gives the
   // number of steps actually issued when the move is aborted.
   task automatic model_accept(int xv, int x0v, int n_force);
      int err, aerr, n, ns, hi, lo;
      err  = xv - x0v;
      aerr = (err < 0) ? -err : err;
      if (aerr <= c_dx1) begin
         m_led = 1'b1;
         return;
      end
      m_led = 1'b0;
      n = (aerr <= c_dx2) ? c_n_fine : c_n_coarse;
      if (n == 0) return;
      ns    = (n_force >= 0) ? n_force : n;
      hi    = (c_hi == 0) ? 1 : c_hi;
      lo    = (c_lo == 0) ? 1 : c_lo;
      m_dir = (err > 0);
      exp_q.push_back(mk(1, 1, 0, m_dir, 0, 0));
      for (int k = 1; k <= ns; k++) begin
         for (int i = 0; i < hi; i++) exp_q.push_back(mk(1, 1, 1, m_dir, 0, k));
         for (int i = 0; i < lo; i++) exp_q.push_back(mk(1, 1, 0, m_dir, 0, k));
      end
      exp_q.push_back(mk(1, 1, 0, m_dir, 0, ns));
      m_cnt = ns;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         cyc++;
         if (exp_q.size() > 0) e_cur = exp_q.pop_front();
         else                  e_cur = mk(0, 0, 0, m_dir, m_led, m_cnt);
         m_busy_prev = e_cur[EW-1];
         a_cur = {bus.busy, bus.drv_enable_SM, bus.drv_step, bus.drv_dir,
                  bus.led, bus.step_count};
         n_vec++;
         if (a_cur !== e_cur) begin
            n_err++;
            $display("FAIL trace cycle %0d: got busy/en/step/dir/led=%b cnt=%0d, want %b cnt=%0d",
                     cyc, a_cur[EW-1:CW], a_cur[CW-1:0], e_cur[EW-1:CW], e_cur[CW-1:0]);
         end
         if (bus.busy === 1'b1) busy_cyc++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_cfg();
      bus.x0             = DW'(c_x0);
      bus.dx1            = DW'(c_dx1);
      bus.dx2            = DW'(c_dx2);
      bus.step_hi        = PW'(c_hi);
      bus.step_lo        = PW'(c_lo);
      bus.n_fine         = CW'(c_n_fine);
      bus.n_coarse       = CW'(c_n_coarse);
      bus.tr_mode_enable = c_en;
   endtask

   task automatic set_en(bit v);
      c_en = v;
      bus.tr_mode_enable = v;
   endtask

   // Present one strobe; the DUT samples it at the next rising edge.
   task automatic strobe(int xv, int n_force);
      bus.x = DW'(xv);
      bus.data_valid = 1'b1;
      @(posedge clk);
      if (c_en && !m_busy_prev) model_accept(xv, c_x0, n_force);
      #1 bus.data_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      m_dir = 0; m_led = 0; m_cnt = 0; m_busy_prev = 0;
      #1 rst = 1'b0;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 2000;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_vec++;
      if (budget == 0) begin
         n_err++;
         $display("FAIL drain timeout: got %0d entries left, want 0", exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic check_lit(string name, int act, int expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, expv);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      c_x0 = 5; c_dx1 = 7; c_dx2 = 12; c_hi = 2; c_lo = 3;
      c_n_fine = 4; c_n_coarse = 10; c_en = 1;
      apply_cfg();
      bus.x = '0;
      bus.data_valid = 1'b0;
      m_dir = 0; m_led = 0; m_cnt = 0; m_busy_prev = 0;

      // Reset state
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check_lit("reset busy", int'(bus.busy), 0);
      check_lit("reset step_count", int'(bus.step_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // Scenario 1: err=+20, coarse, 10 steps
      busy_cyc = 0;
      strobe(25, -1);
      @(negedge clk);
      check_lit("s1 enable at T+1", int'(bus.drv_enable_SM), 1);
      check_lit("s1 step low at T+1", int'(bus.drv_step), 0);
      @(negedge clk);
      check_lit("s1 first step at T+2", int'(bus.drv_step), 1);
      wait_drain();
      check_lit("s1 busy cycles", busy_cyc, 52);
      check_lit("s1 step_count", int'(bus.step_count), 10);
      check_lit("s1 dir", int'(bus.drv_dir), 1);
      check_lit("s1 led", int'(bus.led), 0);

      // Scenario 2: fine moves in both directions; config change mid-move
      strobe(15, -1);
      wait_drain();
      check_lit("s2a step_count", int'(bus.step_count), 4);
      c_x0 = 30; apply_cfg();
      busy_cyc = 0;
      strobe(18, -1);
      c_hi = 5; apply_cfg();          // must not affect the running move
      wait_drain();
      check_lit("s2b step_count", int'(bus.step_count), 4);
      check_lit("s2b dir", int'(bus.drv_dir), 0);
      check_lit("s2b busy cycles", busy_cyc, 22);
      c_hi = 2; c_x0 = 5; apply_cfg();

      // Scenario 3: deadband samples, then a move clears led
      strobe(8, -1);
      @(negedge clk);
      check_lit("s3 led after +3", int'(bus.led), 1);
      check_lit("s3 busy after +3", int'(bus.busy), 0);
      strobe(0, -1);
      @(negedge clk);
      check_lit("s3 led after -5", int'(bus.led), 1);
      set_en(0);
      strobe(25, -1);                 // ignored, no permit
      @(negedge clk);
      check_lit("s3 disabled strobe busy", int'(bus.busy), 0);
      check_lit("s3 disabled strobe led", int'(bus.led), 1);
      set_en(1);
      strobe(25, -1);
      @(negedge clk);
      check_lit("s3 led cleared", int'(bus.led), 0);
      wait_drain();

      // Scenario 4: abort in 3rd high phase, ignored strobe mid-move
      busy_cyc = 0;
      strobe(25, 3);
      repeat (3) @(posedge clk);
      #1;
      strobe(40, -1);                 // busy: dropped
      repeat (7) @(posedge clk);
      #1 set_en(0);
      wait_drain();
      check_lit("s4 step_count", int'(bus.step_count), 3);
      check_lit("s4 busy cycles", busy_cyc, 17);
      set_en(1);

      // Scenario 5: reset during STEP_HI
      strobe(25, -1);
      @(posedge clk);
      #1 do_reset();
      @(negedge clk);
      check_lit("s5 busy after rst", int'(bus.busy), 0);
      check_lit("s5 step after rst", int'(bus.drv_step), 0);
      check_lit("s5 step_count after rst", int'(bus.step_count), 0);
      strobe(25, -1);
      wait_drain();
      check_lit("s5 fresh step_count", int'(bus.step_count), 10);

      // Scenario 6: boundaries
      c_hi = 0; c_lo = 0; apply_cfg();
      busy_cyc = 0;
      strobe(15, -1);
      wait_drain();
      check_lit("s6 1/1 busy cycles", busy_cyc, 10);
      check_lit("s6 1/1 step_count", int'(bus.step_count), 4);
      strobe(5, -1);
      @(negedge clk);
      c_n_coarse = 0; apply_cfg();
      strobe(25, -1);
      @(negedge clk);
      check_lit("s6 n=0 busy", int'(bus.busy), 0);
      check_lit("s6 n=0 led", int'(bus.led), 0);
      check_lit("s6 n=0 step_count", int'(bus.step_count), 4);
      c_n_coarse = 10; c_x0 = 0; apply_cfg();
      busy_cyc = 0;
      strobe(4095, -1);
      wait_drain();
      check_lit("s6 max err step_count", int'(bus.step_count), 10);
      check_lit("s6 max err dir", int'(bus.drv_dir), 1);
      check_lit("s6 max err busy", busy_cyc, 22);
      c_x0 = 4095; apply_cfg();
      strobe(0, -1);
      wait_drain();
      check_lit("s6 min err dir", int'(bus.drv_dir), 0);
      check_lit("s6 min err step_count", int'(bus.step_count), 10);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, want finish before timeout");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tr_step_ctrl.md
Name: tr_step_ctrl

Overview:
Parametrised successor to the TR/TR_pulse pair. Compares each valid ADC sample against a programmable setpoint with two thresholds (deadband, coarse band). It then emits a bounded burst of stepper-driver step pulses with programmable timing and direction. This merges the threshold decision and the pulse generator into one block with configurable widths, per-band step counts, safe abort and a status/step counter. It sits between the ADC capture logic and the stepper driver pins.

Parameters:
DW, 12, width of the ADC sample and thresholds (unsigned)
CW, 10, width of the step-count configuration and counters
PW, 8, width of the pulse high/low timing fields, in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data_valid  in  1  one-cycle strobe; x valid this cycle
tr_mode_enable  in  1  tracking permit; 0 = hold/abort
x  in  DW  ADC sample, unsigned
x0  in  DW  setpoint, unsigned
dx1  in  DW  deadband half-width
dx2  in  DW  coarse threshold; dx2 >= dx1 is required of the user
step_hi  in  PW  step high time in cycles; 0 is treated as 1
step_lo  in  PW  step low time in cycles; 0 is treated as 1
n_fine  in  CW  steps per move when dx1 < |err| <= dx2
n_coarse  in  CW  steps per move when |err| > dx2
drv_enable_SM  out  1  driver enable, high while a move is active
drv_step  out  1  step pulse to driver
drv_dir  out  1  1 = err positive (x > x0), 0 = otherwise
busy  out  1  high in every state except IDLE
led  out  1  1 when the last evaluated sample fell in the deadband
step_count  out  CW  steps issued in the current or last move

Behaviour:
- Reset state:
  - State = IDLE.
  - drv_enable_SM, drv_step, drv_dir, busy, led = 0; step_count = 0.
  - rst dominates all other inputs in any state; outputs are 0 on the cycle after rst is sampled high.
- Error computation: err = x - x0, signed and DW+1 bits wide; |err| is computed in DW+1 bits, so there is no overflow at the extremes.
- IDLE: when data_valid=1 and tr_mode_enable=1, sample x, x0, dx1, dx2, n_fine, n_coarse, step_hi and step_lo into working registers. Mid-move changes to these inputs therefore have no effect.
  - |err| <= dx1: led <= 1, no move, stay IDLE.
  - dx1 < |err| <= dx2: n = n_fine. Otherwise n = n_coarse. In both cases led <= 0.
  - If n == 0: no move, stay IDLE, step_count unchanged.
  - Otherwise: step_count <= 0, drv_dir <= (err > 0), go to SETUP.
- data_valid with tr_mode_enable=0 is ignored; led holds its value.
- SETUP (1 cycle): drv_enable_SM = 1, drv_dir stable, drv_step = 0. Go to STEP_HI.
- STEP_HI: drv_step = 1 for max(step_hi,1) cycles.
  - step_count increments on entry to STEP_HI.
  - Then go to STEP_LO.
- STEP_LO: drv_step = 0 for max(step_lo,1) cycles. Then:
  - If step_count == n, or tr_mode_enable == 0: go to DONE.
  - Otherwise: go to STEP_HI.
- DONE (1 cycle): drv_enable_SM stays 1, drv_step = 0. Next state is IDLE.
- Timing and visibility:
  - drv_enable_SM drops on IDLE entry.
  - drv_dir holds its last value in IDLE.
  - Latency: data_valid at cycle T gives drv_enable_SM=1 at T+1 and the first drv_step=1 at T+2.
  - A full move is 1 + n*(hi+lo) + 1 busy cycles.
- Abort: a tr_mode_enable fall never truncates a pulse. The current high phase and its full low phase complete, then DONE and IDLE. step_count reports the steps actually issued.
- data_valid while busy=1 is ignored and not queued.
- drv_dir never changes while drv_enable_SM = 1.

Test Plan:
- Setup for the numbered scenarios: DW=12; x0=5, dx1=7, dx2=12, step_hi=2, step_lo=3, n_fine=4, n_coarse=10, enable=1.
- Scenario 1: x=25 (err=+20) -> dir=1, 10 pulses each 2 high / 3 low, first step at T+2, busy 52 cycles, step_count=10, led=0.
- Scenario 2: x=15 (err=+10) -> 4 pulses, dir=1, step_count=4. Then with x0=30, x=18 (err=-12) -> 4 pulses, dir=0.
- Scenario 3: x=8 (err=+3) and x=0 (err=-5) -> no pulses, busy stays 0, led=1. A following x=25 sets led=0 at evaluation.
- Scenario 4: x=25, drop enable during the 3rd high phase -> 3rd pulse stays 2 cycles high, 3 low, then DONE/IDLE, step_count=3. Extra data_valid strobes during the move are ignored.
- Scenario 5: rst high during STEP_HI of a coarse move -> next cycle all outputs 0, state IDLE. After release, data_valid with x=25 starts a fresh 10-step move.
- Scenario 6 (boundaries): step_hi=0, step_lo=0 -> 1/1-cycle pulses. n_coarse=0 with x=25 -> no move. x=4095, x0=0 on DW=12 -> err=+4095 is coarse with no wrap.
